// File: rtl/config_chain_segment_if.sv
// ============================================================================
// Module  : config_chain_segment_if
// Brief   : Serial configuration chain bundle for one chain segment.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface config_chain_segment_if #(
  parameter int CONFIG_WIDTH = 64,
  parameter int COUNT_WIDTH  = 16
);
  logic                    iConfigEnable;
  logic                    iConfigDataIn;
  logic                    iConfigDone;
  logic                    oConfigDataOut;
  logic [CONFIG_WIDTH-1:0] oConfig;
  logic                    oConfigValid;
  logic [COUNT_WIDTH-1:0]  oBitCount;
  logic                    oShortLoad;

  modport master (
    output iConfigEnable, iConfigDataIn, iConfigDone,
    input  oConfigDataOut, oConfig, oConfigValid, oBitCount, oShortLoad
  );

  modport slave (
    input  iConfigEnable, iConfigDataIn, iConfigDone,
    output oConfigDataOut, oConfig, oConfigValid, oBitCount, oShortLoad
  );
endinterface

`default_nettype wire

// File: rtl/config_chain_segment.sv
// ============================================================================
// Module  : config_chain_segment
// Brief   : One scan-chain segment: shifts serial config, commits on done rise.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module config_chain_segment #(
  parameter int CONFIG_WIDTH = 64,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                  iClk,
  input  logic                  iReset,
  config_chain_segment_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;
  localparam logic [1:0] LOCKED = 2'd3;

  logic [1:0]              r_state;
  logic [CONFIG_WIDTH-1:0] r_shift;
  logic [CONFIG_WIDTH-1:0] r_config;
  logic [COUNT_WIDTH-1:0]  r_count;
  logic                    r_valid;
  logic                    r_short;
  logic                    r_done_prev;
  logic                    r_armed;

  logic w_loading;
  logic w_shift;
  logic w_rise;
  logic w_fall;
  logic w_count_sat;
  logic w_short;

  assign w_loading   = (r_state == IDLE) || (r_state == SHIFT);
  assign w_shift     = w_loading && bus.iConfigEnable;
  // A rise only counts once done has been seen low since reset, so a level
  // already high at reset release never triggers a commit.
  assign w_rise      = bus.iConfigDone && !r_done_prev && r_armed;
  assign w_fall      = !bus.iConfigDone && r_done_prev;
  assign w_count_sat = &r_count;
  assign w_short     = (32'(r_count) < 32'(CONFIG_WIDTH));

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_config    <= '0;
      r_count     <= '0;
      r_valid     <= 1'b0;
      r_short     <= 1'b0;
      r_done_prev <= 1'b0;
      r_armed     <= 1'b0;
    end else begin
      r_done_prev <= bus.iConfigDone;
      if (!bus.iConfigDone) begin
        r_armed <= 1'b1;
      end

      case (r_state)
        IDLE, SHIFT: begin
          if (w_shift) begin
            r_shift <= {bus.iConfigDataIn, r_shift[CONFIG_WIDTH-1:1]};
            if (!w_count_sat) begin
              r_count <= r_count + 1'b1;
            end
          end
          // An abort clears the count even if a shift lands in the same cycle.
          if (w_fall) begin
            r_state <= IDLE;
            r_count <= '0;
          end else if (w_rise) begin
            r_state <= COMMIT;
          end else if (w_shift) begin
            r_state <= SHIFT;
          end
        end

        COMMIT: begin
          r_config <= r_shift;
          r_valid  <= 1'b1;
          r_short  <= w_short;
          r_state  <= LOCKED;
        end

        LOCKED: begin
          // Level test also catches a done fall that happened during COMMIT.
          if (!bus.iConfigDone) begin
            r_state <= IDLE;
            r_count <= '0;
            r_valid <= 1'b0;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.oConfigDataOut = r_shift[0];
  assign bus.oConfig        = r_config;
  assign bus.oConfigValid   = r_valid;
  assign bus.oBitCount      = r_count;
  assign bus.oShortLoad     = r_short;

endmodule

`default_nettype wire

// File: tb/tb_config_chain_segment.sv
// ============================================================================
// Module  : tb_config_chain_segment
// Brief   : Self-checking bench: directed table, chained segments, random model.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_config_chain_segment;

  logic clk;
  logic rst;
  logic en;
  logic din;
  logic done;

  int n_checks;
  int n_errors;

  config_chain_segment_if #(.CONFIG_WIDTH(8), .COUNT_WIDTH(16)) if_up ();
  config_chain_segment_if #(.CONFIG_WIDTH(8), .COUNT_WIDTH(16)) if_dn ();
  config_chain_segment_if #(.CONFIG_WIDTH(8), .COUNT_WIDTH(3))  if_sat ();

  assign if_up.iConfigEnable  = en;
  assign if_up.iConfigDataIn  = din;
  assign if_up.iConfigDone    = done;
  assign if_dn.iConfigEnable  = en;
  assign if_dn.iConfigDataIn  = if_up.oConfigDataOut;
  assign if_dn.iConfigDone    = done;
  assign if_sat.iConfigEnable = en;
  assign if_sat.iConfigDataIn = din;
  assign if_sat.iConfigDone   = done;

  config_chain_segment #(.CONFIG_WIDTH(8), .COUNT_WIDTH(16)) u_up (
    .iClk(clk), .iReset(rst), .bus(if_up.slave));
  config_chain_segment #(.CONFIG_WIDTH(8), .COUNT_WIDTH(16)) u_dn (
    .iClk(clk), .iReset(rst), .bus(if_dn.slave));
  config_chain_segment #(.CONFIG_WIDTH(8), .COUNT_WIDTH(3)) u_sat (
    .iClk(clk), .iReset(rst), .bus(if_sat.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en   = 1'b0;
    din  = 1'b0;
    done = 1'b0;
    rst  = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  // Shift n bits LSB-first, then raise done (optionally on the last shift cycle)
  // and wait until the commit edge has passed.
  task automatic load(input logic [15:0] pat, input int n, input bit simul);
    for (int i = 0; i < n; i++) begin
      en  = 1'b1;
      din = pat[i];
      if (simul && i == n - 1) done = 1'b1;
      step();
    end
    en  = 1'b0;
    din = 1'b0;
    if (!(simul && n > 0)) begin
      done = 1'b1;
      step();
    end
    step();
  endtask

  typedef struct {
    logic [15:0] pattern;
    int          nbits;
    bit          simul;
    logic [7:0]  exp_cfg;
    bit          exp_short;
    int          exp_cnt;
  } vec_t;

  vec_t vecs[6];

  // Behavioural reference: a load is "captured" one cycle after the done rise
  // is noticed; while captured the word is frozen until done is low again.
  logic [7:0] m_sr, m_cfg;
  bit         m_valid, m_short, m_prev, m_seen_low, m_captured, m_pending;
  int         m_cnt;

  task automatic model_reset();
    m_sr = 8'h00; m_cfg = 8'h00; m_valid = 0; m_short = 0;
    m_prev = 0; m_seen_low = 0; m_captured = 0; m_pending = 0; m_cnt = 0;
  endtask

  task automatic model_cycle(input bit e, input bit d, input bit dn);
    bit rise, fall;
    rise = dn && !m_prev && m_seen_low;
    fall = !dn && m_prev;
    if (m_pending) begin
      m_cfg      = m_sr;
      m_valid    = 1;
      m_short    = (m_cnt < 8);
      m_pending  = 0;
      m_captured = 1;
    end else if (m_captured) begin
      if (!dn) begin
        m_captured = 0;
        m_valid    = 0;
        m_cnt      = 0;
      end
    end else begin
      if (e) begin
        m_sr  = (m_sr >> 1) | (d ? 8'h80 : 8'h00);
        m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
      end
      if (fall) m_cnt = 0;
      else if (rise) m_pending = 1;
    end
    m_prev = dn;
    if (!dn) m_seen_low = 1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    en = 0; din = 0; done = 0;

    vecs[0] = '{16'h00A5,  8, 1'b0, 8'hA5, 1'b0,  8};
    vecs[1] = '{16'h001F,  5, 1'b0, 8'hF8, 1'b1,  5};
    vecs[2] = '{16'h0000,  0, 1'b0, 8'h00, 1'b1,  0};
    vecs[3] = '{16'h5A3C, 16, 1'b0, 8'h5A, 1'b0, 16};
    vecs[4] = '{16'h0003,  2, 1'b0, 8'hC0, 1'b1,  2};
    vecs[5] = '{16'h00A5,  8, 1'b1, 8'hA5, 1'b0,  8};

    // Reset values while reset is held
    rst = 1'b1;
    #3;
    check("reset_config", {24'h0, if_up.oConfig}, 32'h0);
    check("reset_flags", {29'h0, if_up.oConfigValid, if_up.oShortLoad, if_up.oConfigDataOut}, 32'h0);
    check("reset_count", {16'h0, if_up.oBitCount}, 32'h0);
    step();
    rst = 1'b0;
    step();

    // Directed load table
    for (int v = 0; v < 6; v++) begin
      do_reset();
      load(vecs[v].pattern, vecs[v].nbits, vecs[v].simul);
      check($sformatf("vec%0d_config", v), {24'h0, if_up.oConfig}, {24'h0, vecs[v].exp_cfg});
      check($sformatf("vec%0d_valid", v), {31'h0, if_up.oConfigValid}, 32'h1);
      check($sformatf("vec%0d_short", v), {31'h0, if_up.oShortLoad}, {31'h0, vecs[v].exp_short});
      check($sformatf("vec%0d_count", v), {16'h0, if_up.oBitCount}, vecs[v].exp_cnt);
      check($sformatf("vec%0d_dout", v), {31'h0, if_up.oConfigDataOut}, {31'h0, vecs[v].exp_cfg[0]});
      done = 1'b0;
      step();
      check($sformatf("vec%0d_drop_valid", v), {31'h0, if_up.oConfigValid}, 32'h0);
      check($sformatf("vec%0d_drop_count", v), {16'h0, if_up.oBitCount}, 32'h0);
      check($sformatf("vec%0d_drop_config", v), {24'h0, if_up.oConfig}, {24'h0, vecs[v].exp_cfg});
    end

    // Pass-through across two segments, plus counter saturation on a 3-bit count
    do_reset();
    load(16'hA53C, 16, 1'b0);
    check("chain_dn_config", {24'h0, if_dn.oConfig}, 32'h3C);
    check("chain_up_config", {24'h0, if_up.oConfig}, 32'hA5);
    check("chain_dn_count", {16'h0, if_dn.oBitCount}, 32'd16);
    check("chain_up_count", {16'h0, if_up.oBitCount}, 32'd16);
    check("sat_count", {29'h0, if_sat.oBitCount}, 32'd7);
    check("sat_short", {31'h0, if_sat.oShortLoad}, 32'h1);
    check("sat_config", {24'h0, if_sat.oConfig}, 32'hA5);

    // Enable pulses while locked are ignored
    for (int i = 0; i < 4; i++) begin
      en  = 1'b1;
      din = i[0];
      step();
    end
    en = 1'b0;
    check("locked_config", {24'h0, if_up.oConfig}, 32'hA5);
    check("locked_count", {16'h0, if_up.oBitCount}, 32'd16);
    check("locked_dout", {31'h0, if_up.oConfigDataOut}, 32'h1);
    check("locked_valid", {31'h0, if_up.oConfigValid}, 32'h1);
    done = 1'b0;
    step();
    check("unlock_valid", {31'h0, if_up.oConfigValid}, 32'h0);
    check("unlock_config", {24'h0, if_up.oConfig}, 32'hA5);
    check("unlock_count", {16'h0, if_up.oBitCount}, 32'd0);
    check("unlock_dout", {31'h0, if_up.oConfigDataOut}, 32'h1);

    // Asynchronous reset mid-shift, done held high through release
    do_reset();
    load(16'h00FF, 8, 1'b0);
    done = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      en  = 1'b1;
      din = 1'b1;
      step();
    end
    en = 1'b0;
    check("pre_areset_count", {16'h0, if_up.oBitCount}, 32'd3);
    done = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("areset_config", {24'h0, if_up.oConfig}, 32'h0);
    check("areset_count", {16'h0, if_up.oBitCount}, 32'h0);
    check("areset_flags", {29'h0, if_up.oConfigValid, if_up.oShortLoad, if_up.oConfigDataOut}, 32'h0);
    #3;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("held_done_no_commit", {31'h0, if_up.oConfigValid}, 32'h0);
    done = 1'b0;
    step();
    done = 1'b1;
    step();
    step();
    check("toggle_commit_valid", {31'h0, if_up.oConfigValid}, 32'h1);
    check("toggle_commit_config", {24'h0, if_up.oConfig}, 32'h0);
    check("toggle_commit_short", {31'h0, if_up.oShortLoad}, 32'h1);

    // Randomized stimulus against the reference model
    do_reset();
    model_reset();
    for (int c = 0; c < 600; c++) begin
      en  = ($urandom_range(0, 9) < 6);
      din = $urandom_range(0, 1);
      if ($urandom_range(0, 11) == 0) done = ~done;
      step();
      model_cycle(en, din, done);
      check($sformatf("rand%0d_config", c), {24'h0, if_up.oConfig}, {24'h0, m_cfg});
      check($sformatf("rand%0d_count", c), {16'h0, if_up.oBitCount}, m_cnt);
      check($sformatf("rand%0d_flags", c),
            {29'h0, if_up.oConfigValid, if_up.oShortLoad, if_up.oConfigDataOut},
            {29'h0, m_valid, m_short, m_sr[0]});
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
